branch_predict_unit: RTL and testbench
======================================

# branch_predict_unit

Parametrised successor to the combinational branch resolver: resolves branches and jumps one cycle after issue and adds JAL/JALR link generation. It keeps a 2-bit saturating branch history table (BHT) that the fetch stage queries for taken/not-taken predictions, and raises a redirect when the resolved outcome disagrees with the prediction carried down the pipe. It sits between decode/execute and the PC-select logic.

## Interface
- ADDR_W, 32, PC/address width; must be ≥ JUMP_W+2
- OFFSET_W, 16, branch offset width (sign-extended)
- JUMP_W, 26, J/JAL immediate width
- BHT_DEPTH, 64, BHT entries, power of 2; IDX_W = $clog2(BHT_DEPTH)
- CNT_W, 16, mispredict counter width
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- lookup_valid  in  1  fetch-side prediction request
- lookup_pc  in  ADDR_W  PC to predict
- pred_valid  out  1  prediction result valid, 1 cycle after request
- pred_taken  out  1  predicted taken (counter MSB)
- in_valid  in  1  instruction presented for resolution
- mode  in  4  BranchMode_t (NONE, BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ, J, JR, JAL, JALR)
- pcAddress  in  ADDR_W  PC of the branch
- branchAddressOffset  in  OFFSET_W  word offset
- jumpAddress  in  JUMP_W  jump immediate
- jumpRegisterAddress  in  ADDR_W  register target for JR/JALR
- resultZero, resultNegative, resultPositive  in  1 each  ALU flags
- in_pred_taken  in  1  prediction fetch used for this instruction
- flush  in  1  kill presented and in-flight resolution
- out_valid  out  1  resolution result valid
- redirect  out  1  fetch must restart at redirect_pc
- redirect_pc  out  ADDR_W  corrected PC
- link_valid  out  1  JAL/JALR: link_pc must be written
- link_pc  out  ADDR_W  pcAddress + 4
- mispredict_count  out  CNT_W  saturating count of redirects

## Operation
- Branch target = pcAddress + (sext(branchAddressOffset) << 2), modulo 2^ADDR_W.
- Jump target (J/JAL) = {pcAddress[ADDR_W-1:JUMP_W+2], jumpAddress, 2'b00}; JR/JALR target = jumpRegisterAddress.
- Fall-through = pcAddress + 4, modulo 2^ADDR_W. No delay slot.
- Taken: BEQ zero; BNE !zero; BGEZ zero|positive; BGTZ positive; BLEZ zero|negative; BLTZ negative. Jumps always taken. NONE never taken.
- Conditional: redirect = taken ≠ in_pred_taken; redirect_pc = target if taken, else fall-through.
- Jumps: redirect = 1 always, redirect_pc = jump target. JAL/JALR also assert link_valid.
- NONE: out_valid = 1, redirect = 0, redirect_pc = 0, no BHT update.
- BHT index = pc[IDX_W+1:2]. Counter states 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Each accepted conditional branch increments the counter toward 11 if taken, or decrements toward 00 if not; it saturates at both ends. Jumps and NONE leave the BHT untouched.
- mispredict_count increments on every out_valid & redirect cycle and saturates at all-ones.

## Timing
- Resolution latency: 1 cycle. An instruction accepted at edge N (in_valid & !flush) drives out_valid and all result outputs during cycle N+1.
- Back-to-back issue: one instruction per cycle, no stall.
- Outputs are valid only with out_valid. When out_valid = 0, redirect and link_valid are 0.
- BHT update is committed at the accepting edge.
- Prediction latency: 1 cycle. pred_valid = lookup_valid delayed one cycle.
- Lookup and update to the same index in the same cycle: the lookup returns the pre-update counter.
- flush: the instruction presented in the same cycle is discarded (no update, no count). out_valid is 0 in the next cycle. Prediction lookups are unaffected.
- Reset (async assert, sync deassert via clk): all outputs 0, all counters 01, mispredict_count 0. Reset mid-operation drops any in-flight result.

## Structure
- BranchModesPackage: BranchMode_t gains JAL and JALR. Add a bht_counter_t 2-bit typedef with constants for the four counter states.
- Sub-module branch_history_table (parameters BHT_DEPTH, IDX_W). Flop array with one registered read port and one update port, async reset to 01, read-before-write.
- Top module: target/condition logic, result registers, mispredict counter.

## Test plan
- Reset, then lookup pc AABBCCDD → pred_valid=1, pred_taken=0 next cycle. All resolution outputs are 0 during reset.
- BEQ, pc AABBCCDD, offset FFFF, zero=1, in_pred_taken=0 → next cycle redirect=1, redirect_pc AABBCCD9, mispredict_count=1. Lookup of AABBCCDD then gives pred_taken=1.
- BNE, zero=1, in_pred_taken=1, pc AABBCCDD → redirect=1, redirect_pc AABBCCE1. BLEZ, offset 0FFF, negative=1, in_pred_taken=1 → redirect=0. Wrap check: BEQ, pc FFFFFFFC, offset 0001, taken, predicted NT → redirect_pc 00000000.
- J, jump AABBCC, pc AABBCCDD → redirect_pc A2AAEF30. JAL with the same inputs → link_valid=1, link_pc AABBCCE1. JR with jumpRegisterAddress ABCDABCD → redirect_pc ABCDABCD, link_valid=0.
- Saturation: four taken BGTZ at one pc → counter stays 11. One not-taken then predicts taken (10); two more not-taken then predict not taken (00).
- flush in the same cycle as a mispredicting BEQ → out_valid=0 next cycle, counter and mispredict_count unchanged. Same-index lookup and update in one cycle → lookup returns the old counter.

Source files
------------

// File: rtl/branch_predict_unit_pkg.sv
// Branch mode encodings, BHT counter type and the saturating counter update
// shared by the branch prediction/resolution unit and its history table.
package BranchModesPackage;

  typedef enum logic [3:0] {
    NONE = 4'd0,
    BEQ  = 4'd1,
    BNE  = 4'd2,
    BGEZ = 4'd3,
    BGTZ = 4'd4,
    BLEZ = 4'd5,
    BLTZ = 4'd6,
    J    = 4'd7,
    JR   = 4'd8,
    JAL  = 4'd9,
    JALR = 4'd10
  } BranchMode_t;

  typedef logic [1:0] bht_counter_t;

  localparam bht_counter_t BHT_STRONG_NT = 2'b00;
  localparam bht_counter_t BHT_WEAK_NT   = 2'b01;
  localparam bht_counter_t BHT_WEAK_T    = 2'b10;
  localparam bht_counter_t BHT_STRONG_T  = 2'b11;

  function automatic bht_counter_t bhtNext(input bht_counter_t cnt, input logic taken);
    if (taken) return (cnt == BHT_STRONG_T) ? cnt : cnt + 2'd1;
    return (cnt == BHT_STRONG_NT) ? cnt : cnt - 2'd1;
  endfunction

  function automatic logic isConditional(input BranchMode_t mode);
    return mode inside {BEQ, BNE, BGEZ, BGTZ, BLEZ, BLTZ};
  endfunction

endpackage

// File: rtl/branch_predict_unit_if.sv
// Fetch-lookup, resolution-request and resolution-result signals of the
// branch prediction unit; master drives requests, slave is the unit.
interface branch_predict_unit_if #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 16,
  parameter int JUMP_W   = 26,
  parameter int CNT_W    = 16
);
  import BranchModesPackage::*;

  logic                lookup_valid;
  logic [ADDR_W-1:0]   lookup_pc;
  logic                pred_valid;
  logic                pred_taken;

  logic                in_valid;
  BranchMode_t         mode;
  logic [ADDR_W-1:0]   pcAddress;
  logic [OFFSET_W-1:0] branchAddressOffset;
  logic [JUMP_W-1:0]   jumpAddress;
  logic [ADDR_W-1:0]   jumpRegisterAddress;
  logic                resultZero;
  logic                resultNegative;
  logic                resultPositive;
  logic                in_pred_taken;
  logic                flush;

  logic                out_valid;
  logic                redirect;
  logic [ADDR_W-1:0]   redirect_pc;
  logic                link_valid;
  logic [ADDR_W-1:0]   link_pc;
  logic [CNT_W-1:0]    mispredict_count;

  modport master (
    output lookup_valid, lookup_pc, in_valid, mode, pcAddress, branchAddressOffset,
           jumpAddress, jumpRegisterAddress, resultZero, resultNegative,
           resultPositive, in_pred_taken, flush,
    input  pred_valid, pred_taken, out_valid, redirect, redirect_pc, link_valid,
           link_pc, mispredict_count
  );

  modport slave (
    input  lookup_valid, lookup_pc, in_valid, mode, pcAddress, branchAddressOffset,
           jumpAddress, jumpRegisterAddress, resultZero, resultNegative,
           resultPositive, in_pred_taken, flush,
    output pred_valid, pred_taken, out_valid, redirect, redirect_pc, link_valid,
           link_pc, mispredict_count
  );

endinterface

// File: rtl/branch_predict_unit_bht.sv
// 2-bit saturating branch history table: one registered read port, one update
// port; a same-index read and update returns the pre-update counter.
module branch_history_table
  import BranchModesPackage::*;
#(
  parameter int BHT_DEPTH = 64,
  parameter int IDX_W     = $clog2(BHT_DEPTH)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdEn,
  input  logic [IDX_W-1:0] rdIdx,
  output bht_counter_t rdData,
  input  logic         wrEn,
  input  logic [IDX_W-1:0] wrIdx,
  input  logic         wrTaken
);

  bht_counter_t counters [BHT_DEPTH];

  // NOTE: every counter must start weakly not-taken, so this array is a flop
  // bank with async reset rather than a RAM; non-blocking writes give the
  // read-before-write ordering for free.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) counters[i] <= BHT_WEAK_NT;
      rdData <= BHT_WEAK_NT;
    end else begin
      if (rdEn) rdData <= counters[rdIdx];
      if (wrEn) counters[wrIdx] <= bhtNext(counters[wrIdx], wrTaken);
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch/jump resolver with JAL/JALR link generation, BHT-based fetch
// prediction and a saturating mispredict counter. One-cycle latency.
module branch_predict_unit
  import BranchModesPackage::*;
#(
  parameter int ADDR_W    = 32,
  parameter int OFFSET_W  = 16,
  parameter int JUMP_W    = 26,
  parameter int BHT_DEPTH = 64,
  parameter int CNT_W     = 16
) (
  input logic clk,
  input logic rst,
  branch_predict_unit_if.slave bus
);

  localparam int IDX_W = $clog2(BHT_DEPTH);
  localparam logic [ADDR_W-1:0] JUMP_MASK = ADDR_W'({(JUMP_W + 2){1'b1}});

  logic              accept;
  logic              taken;
  logic              redirectNext;
  logic              linkNext;
  logic [ADDR_W-1:0] branchTarget;
  logic [ADDR_W-1:0] jumpTarget;
  logic [ADDR_W-1:0] fallThrough;
  logic [ADDR_W-1:0] redirectPcNext;

  logic              predValid;
  bht_counter_t      predCounter;
  logic              outValid;
  logic              redirectQ;
  logic [ADDR_W-1:0] redirectPcQ;
  logic              linkValidQ;
  logic [ADDR_W-1:0] linkPcQ;
  logic [CNT_W-1:0]  mispredictCount;

  logic              unusedLookupBits;
  assign unusedLookupBits = ^{bus.lookup_pc[ADDR_W-1:IDX_W+2], bus.lookup_pc[1:0]};

  assign accept       = bus.in_valid & ~bus.flush;
  assign branchTarget = bus.pcAddress + (ADDR_W'($signed(bus.branchAddressOffset)) << 2);
  assign jumpTarget   = (bus.pcAddress & ~JUMP_MASK) | (ADDR_W'(bus.jumpAddress) << 2);
  assign fallThrough  = bus.pcAddress + ADDR_W'(4);

  // NOTE: every output of this block gets a default first so no path leaves
  // a signal unassigned and infers a latch.
  always_comb begin
    taken          = 1'b0;
    redirectNext   = 1'b0;
    redirectPcNext = '0;
    linkNext       = 1'b0;
    unique case (bus.mode)
      BEQ:  taken = bus.resultZero;
      BNE:  taken = ~bus.resultZero;
      BGEZ: taken = bus.resultZero | bus.resultPositive;
      BGTZ: taken = bus.resultPositive;
      BLEZ: taken = bus.resultZero | bus.resultNegative;
      BLTZ: taken = bus.resultNegative;
      default: taken = 1'b0;
    endcase
    if (isConditional(bus.mode)) begin
      redirectNext   = taken ^ bus.in_pred_taken;
      redirectPcNext = taken ? branchTarget : fallThrough;
    end else begin
      unique case (bus.mode)
        J, JAL: begin
          redirectNext   = 1'b1;
          redirectPcNext = jumpTarget;
        end
        JR, JALR: begin
          redirectNext   = 1'b1;
          redirectPcNext = bus.jumpRegisterAddress;
        end
        default: ;
      endcase
      linkNext = (bus.mode == JAL) || (bus.mode == JALR);
    end
  end

  branch_history_table #(
    .BHT_DEPTH (BHT_DEPTH),
    .IDX_W     (IDX_W)
  ) u_bht (
    .clk     (clk),
    .rst     (rst),
    .rdEn    (bus.lookup_valid),
    .rdIdx   (bus.lookup_pc[IDX_W+1:2]),
    .rdData  (predCounter),
    .wrEn    (accept & isConditional(bus.mode)),
    .wrIdx   (bus.pcAddress[IDX_W+1:2]),
    .wrTaken (taken)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      predValid       <= 1'b0;
      outValid        <= 1'b0;
      redirectQ       <= 1'b0;
      redirectPcQ     <= '0;
      linkValidQ      <= 1'b0;
      linkPcQ         <= '0;
      mispredictCount <= '0;
    end else begin
      predValid   <= bus.lookup_valid;
      outValid    <= accept;
      redirectQ   <= accept & redirectNext;
      redirectPcQ <= accept ? redirectPcNext : '0;
      linkValidQ  <= accept & linkNext;
      linkPcQ     <= accept ? fallThrough : '0;
      // Counted at the accepting edge so the count already includes the
      // redirect being shown on the outputs.
      if (accept && redirectNext && (mispredictCount != '1))
        mispredictCount <= mispredictCount + CNT_W'(1);
    end
  end

  assign bus.pred_valid       = predValid;
  assign bus.pred_taken       = predCounter[1];
  assign bus.out_valid        = outValid;
  assign bus.redirect         = redirectQ;
  assign bus.redirect_pc      = redirectPcQ;
  assign bus.link_valid       = linkValidQ;
  assign bus.link_pc          = linkPcQ;
  assign bus.mispredict_count = mispredictCount;

endmodule

// File: tb/tb_branch_predict_unit.sv
// Directed, table-driven bench for branch_predict_unit: resolution vectors,
// BHT prediction/saturation, flush, same-index lookup and reset behaviour.
module tb_branch_predict_unit;
  import BranchModesPackage::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  branch_predict_unit_if bus ();

  branch_predict_unit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    BranchMode_t mode;
    logic [31:0] pc;
    logic [15:0] off;
    logic [25:0] jmp;
    logic [31:0] jr;
    logic        z, n, p, predIn;
    logic        expRedirect;
    logic [31:0] expPc;
    logic        expLink;
    logic [31:0] expLinkPc;
  } vec_t;

  vec_t vecs [12];
  int   nChecks = 0;
  int   nFail   = 0;
  int   expCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle();
    bus.in_valid            = 1'b0;
    bus.flush               = 1'b0;
    bus.mode                = NONE;
    bus.lookup_valid        = 1'b0;
    bus.lookup_pc           = '0;
    bus.pcAddress           = '0;
    bus.branchAddressOffset = '0;
    bus.jumpAddress         = '0;
    bus.jumpRegisterAddress = '0;
    bus.resultZero          = 1'b0;
    bus.resultNegative      = 1'b0;
    bus.resultPositive      = 1'b0;
    bus.in_pred_taken       = 1'b0;
  endtask

  task automatic drive(input vec_t v, input logic fl);
    bus.in_valid            = 1'b1;
    bus.flush               = fl;
    bus.mode                = v.mode;
    bus.pcAddress           = v.pc;
    bus.branchAddressOffset = v.off;
    bus.jumpAddress         = v.jmp;
    bus.jumpRegisterAddress = v.jr;
    bus.resultZero          = v.z;
    bus.resultNegative      = v.n;
    bus.resultPositive      = v.p;
    bus.in_pred_taken       = v.predIn;
  endtask

  function automatic vec_t mkCond(input BranchMode_t m, input logic [31:0] pc,
                                  input logic z, input logic n, input logic p,
                                  input logic predIn);
    vec_t v;
    v = '{m, pc, 16'h0010, 26'h0, 32'h0, z, n, p, predIn, 1'b0, 32'h0, 1'b0, 32'h0};
    return v;
  endfunction

  task automatic lookup(input logic [31:0] pc, input logic exp, input string name);
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = pc;
    @(negedge clk);
    check({name, ".pred_valid"}, 32'(bus.pred_valid), 32'd1);
    check({name, ".pred_taken"}, 32'(bus.pred_taken), 32'(exp));
    bus.lookup_valid = 1'b0;
  endtask

  // Resolves one non-redirecting conditional branch (used for BHT training).
  task automatic train(input logic [31:0] pc, input logic tk, input string name);
    drive(mkCond(BGTZ, pc, 1'b0, 1'b0, tk, tk), 1'b0);
    @(negedge clk);
    check({name, ".out_valid"}, 32'(bus.out_valid), 32'd1);
    check({name, ".redirect"}, 32'(bus.redirect), 32'd0);
    idle();
  endtask

  initial begin
    vecs[0]  = '{BEQ,  32'hAABBCCDD, 16'hFFFF, 26'h0, 32'h0, 1, 0, 0, 0, 1, 32'hAABBCCD9, 0, 32'h0};
    vecs[1]  = '{BNE,  32'hAABBCCDD, 16'hFFFF, 26'h0, 32'h0, 1, 0, 0, 1, 1, 32'hAABBCCE1, 0, 32'h0};
    vecs[2]  = '{BLEZ, 32'hAABBCCDD, 16'h0FFF, 26'h0, 32'h0, 0, 1, 0, 1, 0, 32'hAABC0CD9, 0, 32'h0};
    vecs[3]  = '{BEQ,  32'hFFFFFFFC, 16'h0001, 26'h0, 32'h0, 1, 0, 0, 0, 1, 32'h00000000, 0, 32'h0};
    vecs[4]  = '{J,    32'hAABBCCDD, 16'h0, 26'hAABBCC, 32'h0, 0, 0, 0, 0, 1, 32'hA2AAEF30, 0, 32'h0};
    vecs[5]  = '{JAL,  32'hAABBCCDD, 16'h0, 26'hAABBCC, 32'h0, 0, 0, 0, 0, 1, 32'hA2AAEF30, 1, 32'hAABBCCE1};
    vecs[6]  = '{JR,   32'hAABBCCDD, 16'h0, 26'h0, 32'hABCDABCD, 0, 0, 0, 0, 1, 32'hABCDABCD, 0, 32'h0};
    vecs[7]  = '{JALR, 32'h00001000, 16'h0, 26'h0, 32'h12345678, 0, 0, 0, 0, 1, 32'h12345678, 1, 32'h00001004};
    vecs[8]  = '{NONE, 32'hAABBCCDD, 16'hFFFF, 26'hAABBCC, 32'hABCDABCD, 1, 0, 0, 1, 0, 32'h0, 0, 32'h0};
    vecs[9]  = '{BGEZ, 32'h00000100, 16'h0010, 26'h0, 32'h0, 0, 0, 1, 1, 0, 32'h00000140, 0, 32'h0};
    vecs[10] = '{BGTZ, 32'h00000100, 16'h0010, 26'h0, 32'h0, 1, 0, 0, 0, 0, 32'h00000104, 0, 32'h0};
    vecs[11] = '{BLTZ, 32'h00000200, 16'hFFF0, 26'h0, 32'h0, 0, 1, 0, 0, 1, 32'h000001C0, 0, 32'h0};

    // Reset: outputs stay low even with requests presented.
    idle();
    drive(vecs[4], 1'b0);
    bus.lookup_valid = 1'b1;
    repeat (2) @(negedge clk);
    check("rst.out_valid", 32'(bus.out_valid), 32'd0);
    check("rst.redirect", 32'(bus.redirect), 32'd0);
    check("rst.redirect_pc", bus.redirect_pc, 32'd0);
    check("rst.link_valid", 32'(bus.link_valid), 32'd0);
    check("rst.mispredict_count", 32'(bus.mispredict_count), 32'd0);
    check("rst.pred_valid", 32'(bus.pred_valid), 32'd0);
    idle();
    rst = 1'b1;
    @(negedge clk);
    lookup(32'hAABBCCDD, 1'b0, "lk_reset");
    @(negedge clk);
    check("lk_idle.pred_valid", 32'(bus.pred_valid), 32'd0);

    // Back-to-back resolution vectors.
    for (int i = 0; i < 12; i++) begin
      drive(vecs[i], 1'b0);
      @(negedge clk);
      expCount += int'(vecs[i].expRedirect);
      check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'd1);
      check($sformatf("vec%0d.redirect", i), 32'(bus.redirect), 32'(vecs[i].expRedirect));
      check($sformatf("vec%0d.redirect_pc", i), bus.redirect_pc, vecs[i].expPc);
      check($sformatf("vec%0d.link_valid", i), 32'(bus.link_valid), 32'(vecs[i].expLink));
      if (vecs[i].expLink)
        check($sformatf("vec%0d.link_pc", i), bus.link_pc, vecs[i].expLinkPc);
      check($sformatf("vec%0d.mispredict_count", i), 32'(bus.mispredict_count), 32'(expCount));
    end
    idle();
    @(negedge clk);
    check("idle.out_valid", 32'(bus.out_valid), 32'd0);
    check("idle.redirect", 32'(bus.redirect), 32'd0);

    // BHT contents left by the table.
    lookup(32'hAABBCCDD, 1'b1, "lk_55");
    lookup(32'hFFFFFFFC, 1'b1, "lk_63");
    lookup(32'h00000200, 1'b1, "lk_0");

    // Saturation at both ends of one counter.
    for (int i = 0; i < 4; i++) train(32'h00000040, 1'b1, $sformatf("sat_t%0d", i));
    lookup(32'h00000040, 1'b1, "sat_top");
    train(32'h00000040, 1'b0, "sat_nt0");
    lookup(32'h00000040, 1'b1, "sat_weak_t");
    train(32'h00000040, 1'b0, "sat_nt1");
    train(32'h00000040, 1'b0, "sat_nt2");
    lookup(32'h00000040, 1'b0, "sat_strong_nt");
    train(32'h00000040, 1'b0, "sat_nt3");
    train(32'h00000040, 1'b1, "sat_t4");
    lookup(32'h00000040, 1'b0, "sat_bottom");
    check("sat.mispredict_count", 32'(bus.mispredict_count), 32'(expCount));

    // Flush of a mispredicting branch: no result, no count, no BHT update.
    drive(mkCond(BEQ, 32'h00000080, 1'b1, 1'b0, 1'b0, 1'b0), 1'b1);
    @(negedge clk);
    check("flush.out_valid", 32'(bus.out_valid), 32'd0);
    check("flush.redirect", 32'(bus.redirect), 32'd0);
    check("flush.mispredict_count", 32'(bus.mispredict_count), 32'(expCount));
    idle();
    lookup(32'h00000080, 1'b0, "flush_bht");

    // Same-index lookup and update: lookup sees the old counter.
    bus.lookup_valid = 1'b1;
    bus.lookup_pc    = 32'h000000C0;
    drive(mkCond(BEQ, 32'h000000C0, 1'b1, 1'b0, 1'b0, 1'b1), 1'b0);
    @(negedge clk);
    check("rbw.pred_taken", 32'(bus.pred_taken), 32'd0);
    check("rbw.out_valid", 32'(bus.out_valid), 32'd1);
    check("rbw.redirect", 32'(bus.redirect), 32'd0);
    idle();
    lookup(32'h000000C0, 1'b1, "rbw_after");

    // Reset asserted while a result is being shown.
    drive(vecs[4], 1'b0);
    @(posedge clk);
    #2 rst = 1'b0;
    #1;
    check("midrst.out_valid", 32'(bus.out_valid), 32'd0);
    check("midrst.redirect", 32'(bus.redirect), 32'd0);
    check("midrst.mispredict_count", 32'(bus.mispredict_count), 32'd0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    lookup(32'hAABBCCDD, 1'b0, "lk_midrst");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
